// File: rtl/mig_burst_ctrl.sv
// -----------------------------------------------------------------------------
// mig_burst_ctrl
//
// Burst controller between request-level traffic sources and the Xilinx MIG
// native user interface. A single write or read burst (start address + beat
// count) is accepted at a time and expanded into per-beat MIG commands.
//
// Write bursts stream DATA_W-bit beats from the requester straight onto the
// MIG write-data FIFO. Each beat's command and data are issued together.
// Read bursts issue one read command per cycle while app_rdy is high. Returned
// data is registered once and forwarded with a valid strobe. A done strobe
// marks the end of each burst.
//
// Optional feature (compile-time macro):
//   MIG_BURST_RR_EN  When defined, wr_req and rd_req are arbitrated
//                    round-robin. After each completed burst, the other
//                    direction gets priority if both requests are pending.
//                    When undefined, write always wins over read.
//
// Ports
//   ui_clk, ui_rstn            MIG UI clock; asynchronous active-low reset
//   init_calib_complete        MIG calibration done; requests wait for it
//   wr_req/wr_req_addr/wr_length   write request, start address, beat count
//   wr_data                    current write beat (advance on wr_data_valid)
//   wr_busy/wr_data_valid/wr_done  busy, beat consumed, burst complete
//   rd_req/rd_req_addr/rd_length   read request, start address, beat count
//   rd_data/rd_data_valid/rd_done  read beat, beat valid, burst complete
//   rd_busy                    busy (same as wr_busy)
//   app_*                      MIG native UI command / write / read channels
// -----------------------------------------------------------------------------
module mig_burst_ctrl #(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 128,
  parameter int ADDR_STEP = 8
) (
  input  logic                  ui_clk,
  input  logic                  ui_rstn,
  input  logic                  init_calib_complete,

  // Write request side
  input  logic                  wr_req,
  input  logic [ADDR_W-1:0]     wr_req_addr,
  input  logic [15:0]           wr_length,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_busy,
  output logic                  wr_data_valid,
  output logic                  wr_done,

  // Read request side
  input  logic                  rd_req,
  input  logic [ADDR_W-1:0]     rd_req_addr,
  input  logic [15:0]           rd_length,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_busy,
  output logic                  rd_data_valid,
  output logic                  rd_done,

  // MIG native UI
  output logic [ADDR_W-1:0]     app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [DATA_W-1:0]     app_wdf_data,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  input  logic                  app_wdf_rdy,
  output logic [DATA_W/8-1:0]   app_wdf_mask,
  input  logic [DATA_W-1:0]     app_rd_data,
  input  logic                  app_rd_data_valid
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WRITE     = 3'd1;
  localparam logic [2:0] ST_READ_CMD  = 3'd2;
  localparam logic [2:0] ST_READ_WAIT = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;       // address of the next beat/command
  logic [15:0]       len_q, len_d;         // beat count of the active burst
  logic [15:0]       cnt_q, cnt_d;         // beats written / commands issued
  logic [15:0]       rcv_q, rcv_d;         // read beats received
  logic              op_wr_q, op_wr_d;     // active burst is a write
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  // ---------------------------------------------------------------------------
  // Handshake and arbitration helpers
  // ---------------------------------------------------------------------------
  logic              in_read;
  logic              wr_fire;
  logic              cmd_fire;
  logic              rd_beat;
  logic [15:0]       rcv_inc;
  logic              rcv_done;
  logic              req_any;
  logic              pick_wr;
  logic [15:0]       req_len;
  logic              prio_rd;   // 1: read wins when both requests are pending

  assign in_read  = (state_q == ST_READ_CMD) || (state_q == ST_READ_WAIT);
  assign wr_fire  = (state_q == ST_WRITE) && app_rdy && app_wdf_rdy;
  assign cmd_fire = (state_q == ST_READ_CMD) && app_rdy;
  // Returned data outside an active read (e.g. from a burst aborted by reset)
  // is never counted or forwarded.
  assign rd_beat  = in_read && app_rd_data_valid;
  assign rcv_inc  = rcv_q + {15'd0, rd_beat};
  assign rcv_done = (rcv_inc == len_q);

  assign req_any  = init_calib_complete && (wr_req || rd_req);
  assign pick_wr  = wr_req && !(rd_req && prio_rd);
  assign req_len  = pick_wr ? wr_length : rd_length;

`ifdef MIG_BURST_RR_EN
  logic prio_rd_q, prio_rd_d;

  // Hand priority to the opposite direction of the burst just completed.
  always_comb begin
    prio_rd_d = prio_rd_q;
    if (state_q == ST_DONE) begin
      prio_rd_d = op_wr_q;
    end
  end

  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      prio_rd_q <= 1'b0;
    end else begin
      prio_rd_q <= prio_rd_d;
    end
  end

  assign prio_rd = prio_rd_q;
`else
  assign prio_rd = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    rcv_d      = rcv_q;
    op_wr_d    = op_wr_q;
    rd_valid_d = rd_beat;
    rd_data_d  = rd_beat ? app_rd_data : rd_data_q;

    if (in_read) begin
      rcv_d = rcv_inc;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          op_wr_d = pick_wr;
          addr_d  = pick_wr ? wr_req_addr : rd_req_addr;
          len_d   = req_len;
          cnt_d   = 16'd0;
          rcv_d   = 16'd0;
          // A zero-length burst issues nothing and just reports completion.
          if (req_len == 16'd0) begin
            state_d = ST_DONE;
          end else if (pick_wr) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ_CMD;
          end
        end
      end

      ST_WRITE: begin
        if (wr_fire) begin
          addr_d = addr_q + ADDR_W'(ADDR_STEP);
          cnt_d  = cnt_q + 16'd1;
          if (cnt_q == len_q - 16'd1) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_READ_CMD: begin
        if (cmd_fire) begin
          addr_d = addr_q + ADDR_W'(ADDR_STEP);
          cnt_d  = cnt_q + 16'd1;
          if (cnt_q == len_q - 16'd1) begin
            state_d = rcv_done ? ST_DONE : ST_READ_WAIT;
          end
        end
      end

      ST_READ_WAIT: begin
        if (rcv_done) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= 16'd0;
      cnt_q      <= 16'd0;
      rcv_q      <= 16'd0;
      op_wr_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      rcv_q      <= rcv_d;
      op_wr_q    <= op_wr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // MIG-side outputs
  // ---------------------------------------------------------------------------
  // Command and write data go out together: the command is offered only when
  // the data FIFO can take the beat, and the beat is written only when the
  // command is accepted, so both sides fire on the same cycle.
  always_comb begin
    app_en        = 1'b0;
    app_cmd       = CMD_WRITE;
    app_wdf_wren  = 1'b0;
    app_wdf_end   = 1'b0;
    app_wdf_data  = '0;
    wr_data_valid = 1'b0;

    case (state_q)
      ST_WRITE: begin
        app_en        = app_wdf_rdy;
        app_wdf_wren  = app_rdy;
        app_wdf_end   = app_rdy;
        app_wdf_data  = wr_data;
        wr_data_valid = wr_fire;
      end

      ST_READ_CMD: begin
        app_en  = 1'b1;
        app_cmd = CMD_READ;
      end

      default: begin
      end
    endcase
  end

  assign app_addr     = addr_q;
  assign app_wdf_mask = '0;

  // ---------------------------------------------------------------------------
  // Requester-side outputs
  // ---------------------------------------------------------------------------
  // Busy covers the DONE cycle so a registered requester never re-requests off
  // a stale busy=0.
  assign wr_busy       = (state_q != ST_IDLE) || !init_calib_complete;
  assign rd_busy       = wr_busy;
  assign wr_done       = (state_q == ST_DONE) &&  op_wr_q;
  assign rd_done       = (state_q == ST_DONE) && !op_wr_q;
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_valid_q;

endmodule

// File: tb/tb_mig_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mig_burst_ctrl
//
// Directed bench for mig_burst_ctrl. Inputs change on the falling edge and
// outputs are sampled 1 ns later, so every sample sees exactly the values the
// next rising edge acts on. A small in-line MIG read responder returns each
// read command's data 20 cycles after it is issued, carrying the command
// address as the data word.
// -----------------------------------------------------------------------------
module tb_mig_burst_ctrl;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  logic                ui_clk = 1'b0;
  logic                ui_rstn;
  logic                init_calib_complete;
  logic                wr_req;
  logic [ADDR_W-1:0]   wr_req_addr;
  logic [15:0]         wr_length;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_busy, wr_data_valid, wr_done;
  logic                rd_req;
  logic [ADDR_W-1:0]   rd_req_addr;
  logic [15:0]         rd_length;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_busy, rd_data_valid, rd_done;
  logic [ADDR_W-1:0]   app_addr;
  logic [2:0]          app_cmd;
  logic                app_en, app_rdy;
  logic [DATA_W-1:0]   app_wdf_data;
  logic                app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [DATA_W/8-1:0] app_wdf_mask;
  logic [DATA_W-1:0]   app_rd_data;
  logic                app_rd_data_valid;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  typedef struct {
    int                due;
    logic [ADDR_W-1:0] addr;
  } rsp_t;

  mig_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_STEP(8)) dut (
    .ui_clk              (ui_clk),
    .ui_rstn             (ui_rstn),
    .init_calib_complete (init_calib_complete),
    .wr_req              (wr_req),
    .wr_req_addr         (wr_req_addr),
    .wr_length           (wr_length),
    .wr_data             (wr_data),
    .wr_busy             (wr_busy),
    .wr_data_valid       (wr_data_valid),
    .wr_done             (wr_done),
    .rd_req              (rd_req),
    .rd_req_addr         (rd_req_addr),
    .rd_length           (rd_length),
    .rd_data             (rd_data),
    .rd_busy             (rd_busy),
    .rd_data_valid       (rd_data_valid),
    .rd_done             (rd_done),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_wdf_mask        (app_wdf_mask),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid)
  );

  always #5 ui_clk = ~ui_clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a write burst; optionally toggle app_wdf_rdy (1,1,0 repeating) and
  // optionally pull reset once `abort_at` beats have been consumed.
  task automatic do_write(input logic [ADDR_W-1:0] a, input int len,
                          input bit toggle, input int abort_at);
    int  k = 0;
    bit  rdy;
    @(negedge ui_clk);
    init_calib_complete = 1'b1;
    rd_req      = 1'b0;
    wr_req      = 1'b1;
    wr_req_addr = a;
    wr_length   = 16'(len);
    app_rdy     = 1'b1;
    app_wdf_rdy = 1'b1;
    wr_data     = '0;
    #1;
    check("wr_idle_busy", wr_busy, 1'b0);
    for (int c = 0; c < 4 * len + 8 && k < len; c++) begin
      @(negedge ui_clk);
      wr_req      = (c == 0);  // held one extra cycle; must be ignored
      rdy         = toggle ? (c % 3 != 2) : 1'b1;
      app_wdf_rdy = rdy;
      wr_data     = 128'(k);
      if (k == abort_at) begin
        ui_rstn = 1'b0;
        wr_req  = 1'b0;
        #1;
        check("abort_app_en",   app_en,        1'b0);
        check("abort_app_addr", app_addr,      28'h0);
        check("abort_wdv",      wr_data_valid, 1'b0);
        check("abort_wren",     app_wdf_wren,  1'b0);
        check("abort_wdf_data", app_wdf_data,  128'h0);
        check("abort_busy",     wr_busy,       1'b0);
        check("abort_done",     wr_done,       1'b0);
        return;
      end
      #1;
      check("wr_busy",   wr_busy, 1'b1);
      check("wr_app_en", app_en,  rdy);
      if (rdy) begin
        check("wr_fire",     wr_data_valid, 1'b1);
        check("wr_addr",     app_addr,      a + 28'(8 * k));
        check("wr_wdf_data", app_wdf_data,  128'(k));
        check("wr_wren",     app_wdf_wren,  1'b1);
        check("wr_cmd",      app_cmd,       3'b000);
        k++;
      end else begin
        check("wr_no_fire", wr_data_valid, 1'b0);
      end
    end
    check("wr_beats", k, len);
    @(negedge ui_clk);
    app_wdf_rdy = 1'b1;
    #1;
    check("wr_done_pulse", wr_done,       1'b1);
    check("wr_done_busy",  wr_busy,       1'b1);
    check("wr_done_en",    app_en,        1'b0);
    check("wr_done_wdv",   wr_data_valid, 1'b0);
    @(negedge ui_clk);
    #1;
    check("wr_after_done", wr_done, 1'b0);
    check("wr_busy_drop",  wr_busy, 1'b0);
  endtask

  // Issue a read burst; the responder returns data 20 cycles after each command.
  task automatic do_read(input logic [ADDR_W-1:0] a, input int len);
    rsp_t q[$];
    int   got  = 0;
    int   ncmd = 0;
    @(negedge ui_clk);
    wr_req            = 1'b0;
    rd_req            = 1'b1;
    rd_req_addr       = a;
    rd_length         = 16'(len);
    app_rdy           = 1'b1;
    app_rd_data_valid = 1'b0;
    #1;
    check("rd_idle_busy", rd_busy, 1'b0);
    for (int c = 0; c < len + 64 && got < len; c++) begin
      @(negedge ui_clk);
      rd_req            = (c == 0);
      app_rd_data_valid = 1'b0;
      app_rd_data       = '0;
      if (q.size() > 0 && q[0].due <= c) begin
        app_rd_data_valid = 1'b1;
        app_rd_data       = {100'd0, q[0].addr};
        void'(q.pop_front());
      end
      #1;
      check("rd_busy", rd_busy, 1'b1);
      if (rd_data_valid) begin
        check("rd_data",      rd_data, {100'd0, a + 28'(8 * got)});
        check("rd_done_last", rd_done, got == len - 1);
        got++;
      end else begin
        check("rd_done_early", rd_done, 1'b0);
      end
      if (app_en) begin
        check("rd_cmd",       app_cmd,    3'b001);
        check("rd_addr",      app_addr,   a + 28'(8 * ncmd));
        check("rd_cmd_count", ncmd < len, 1'b1);
        q.push_back('{c + 20, app_addr});
        ncmd++;
      end
    end
    check("rd_beats", got,  len);
    check("rd_cmds",  ncmd, len);
    @(negedge ui_clk);
    app_rd_data_valid = 1'b0;
    #1;
    check("rd_after_done", rd_done,       1'b0);
    check("rd_busy_drop",  rd_busy,       1'b0);
    check("rd_valid_drop", rd_data_valid, 1'b0);
  endtask

  initial begin
    logic [2:0] exp_cmd [3];
`ifdef MIG_BURST_RR_EN
    exp_cmd = '{3'b000, 3'b001, 3'b000};
`else
    exp_cmd = '{3'b000, 3'b000, 3'b000};
`endif

    ui_rstn             = 1'b1;
    init_calib_complete = 1'b0;
    wr_req              = 1'b0;
    wr_req_addr         = '0;
    wr_length           = 16'd0;
    wr_data             = '1;
    rd_req              = 1'b0;
    rd_req_addr         = '0;
    rd_length           = 16'd0;
    app_rdy             = 1'b0;
    app_wdf_rdy         = 1'b0;
    app_rd_data         = '1;
    app_rd_data_valid   = 1'b1;
    #2 ui_rstn = 1'b0;

    // Reset state: outputs 0, busy high while uncalibrated, read path blocked.
    @(negedge ui_clk);
    #1;
    check("rst_app_en",   app_en,        1'b0);
    check("rst_app_addr", app_addr,      28'h0);
    check("rst_app_cmd",  app_cmd,       3'b000);
    check("rst_wdf_data", app_wdf_data,  128'h0);
    check("rst_wren",     app_wdf_wren,  1'b0);
    check("rst_wend",     app_wdf_end,   1'b0);
    check("rst_mask",     app_wdf_mask,  16'h0);
    check("rst_wr_busy",  wr_busy,       1'b1);
    check("rst_rd_busy",  rd_busy,       1'b1);
    check("rst_wdv",      wr_data_valid, 1'b0);
    check("rst_rd_data",  rd_data,       128'h0);
    check("rst_rd_valid", rd_data_valid, 1'b0);
    check("rst_wr_done",  wr_done,       1'b0);
    check("rst_rd_done",  rd_done,       1'b0);

    // Calibration gate: wr_req held while uncalibrated is not accepted.
    @(negedge ui_clk);
    ui_rstn           = 1'b1;
    app_rd_data_valid = 1'b0;
    app_rd_data       = '0;
    wr_req            = 1'b1;
    wr_req_addr       = 28'h40;
    wr_length         = 16'd4;
    app_rdy           = 1'b1;
    app_wdf_rdy       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ui_clk);
      #1;
      check("cal_busy",   wr_busy, 1'b1);
      check("cal_rbusy",  rd_busy, 1'b1);
      check("cal_no_en",  app_en,  1'b0);
    end
    // Calibration rises with the request still held: accepted.
    do_write(28'h40, 4, 1'b0, -1);

    // Full-rate 256-beat write from address 0.
    do_write(28'h0, 256, 1'b0, -1);

    // 16-beat write with app_wdf_rdy toggling.
    do_write(28'h1000, 16, 1'b1, -1);

    // 256-beat read from 0x100, 20-cycle read latency.
    do_read(28'h100, 256);

    // Zero-length read: done one cycle after accept, no commands.
    @(negedge ui_clk);
    rd_req      = 1'b1;
    rd_req_addr = 28'h500;
    rd_length   = 16'd0;
    #1;
    @(negedge ui_clk);
    rd_req = 1'b0;
    #1;
    check("rd0_done",    rd_done, 1'b1);
    check("rd0_no_en",   app_en,  1'b0);
    check("rd0_busy",    rd_busy, 1'b1);
    check("rd0_wr_done", wr_done, 1'b0);
    @(negedge ui_clk);
    #1;
    check("rd0_done_drop", rd_done, 1'b0);
    check("rd0_busy_drop", rd_busy, 1'b0);
    check("rd0_no_en2",    app_en,  1'b0);

    // Reset at beat 100 of a 256-beat write, then a fresh 4-beat write.
    do_write(28'h800, 256, 1'b0, 100);
    @(negedge ui_clk);
    ui_rstn = 1'b1;
    do_write(28'h2000, 4, 1'b0, -1);

    // Simultaneous requests for 3 bursts, starting from reset priority.
    @(negedge ui_clk);
    ui_rstn = 1'b0;
    @(negedge ui_clk);
    ui_rstn = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge ui_clk);
      wr_req            = 1'b1;
      rd_req            = 1'b1;
      wr_req_addr       = 28'h3000;
      rd_req_addr       = 28'h4000;
      wr_length         = 16'd1;
      rd_length         = 16'd1;
      app_rdy           = 1'b1;
      app_wdf_rdy       = 1'b1;
      app_rd_data_valid = 1'b0;
      #1;
      @(negedge ui_clk);
      wr_req = 1'b0;
      rd_req = 1'b0;
      #1;
      check("arb_dir", app_cmd, exp_cmd[b]);
      check("arb_en",  app_en,  1'b1);
      if (exp_cmd[b] == 3'b000) begin
        @(negedge ui_clk);
        #1;
        check("arb_wr_done", wr_done, 1'b1);
      end else begin
        @(negedge ui_clk);
        app_rd_data_valid = 1'b1;
        app_rd_data       = 128'h5A;
        #1;
        @(negedge ui_clk);
        app_rd_data_valid = 1'b0;
        app_rd_data       = '0;
        #1;
        check("arb_rd_done", rd_done, 1'b1);
        check("arb_rd_data", rd_data, 128'h5A);
      end
      @(negedge ui_clk);
      #1;
      check("arb_idle", wr_busy, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mig_burst_ctrl.md
# mig_burst_ctrl

Burst controller between the team's request-level traffic sources (test generators, frame writers) and the Xilinx MIG native user interface. Accepts one write or read burst request at a time, given as start address plus beat count, and expands it into per-beat MIG commands. Streams 128-bit write data from the requester and returns read data with valid and done strobes.

## Interface
- ADDR_W, 28, MIG app_addr width
- DATA_W, 128, MIG UI data width (one beat)
- ADDR_STEP, 8, app_addr increment per beat (DDR3 x16, BL8)

- ui_clk  in  1  MIG UI clock
- ui_rstn  in  1  reset, asynchronous, active-low
- init_calib_complete  in  1  MIG calibration done
- wr_req / wr_req_addr / wr_length  in  1 / ADDR_W / 16  write request, start address, beat count
- wr_data  in  DATA_W  current write beat
- wr_busy / wr_data_valid / wr_done  out  1 / 1 / 1  busy, beat consumed, burst complete
- rd_req / rd_req_addr / rd_length  in  1 / ADDR_W / 16  read request, start address, beat count
- rd_data  out  DATA_W  read beat
- rd_busy / rd_data_valid / rd_done  out  1 / 1 / 1  busy, read beat valid, burst complete
- app_addr  out  ADDR_W; app_cmd  out  3 (000 write, 001 read); app_en  out  1; app_rdy  in  1
- app_wdf_data  out  DATA_W; app_wdf_wren / app_wdf_end  out  1; app_wdf_rdy  in  1; app_wdf_mask  out  DATA_W/8 (tied 0)
- app_rd_data  in  DATA_W; app_rd_data_valid  in  1

## Operation
- States: IDLE, WRITE, READ_CMD, READ_WAIT, DONE.
- IDLE: requests are sampled only when init_calib_complete=1. If both requests are high, write wins (see Configuration). On accept: latch address and length, clear counters. Length 0 goes straight to DONE; no MIG commands are issued.
- WRITE:
  - app_en = app_wdf_rdy.
  - app_wdf_wren = app_wdf_end = app_rdy.
  - app_cmd = 000; app_wdf_data = wr_data (combinational).
  - A beat fires when app_rdy && app_wdf_rdy. wr_data_valid = fire, which means wr_data is consumed this cycle and the requester presents the next word next cycle.
  - Each fire increments app_addr by ADDR_STEP. After beat wr_length-1 fires, go to DONE.
- READ_CMD:
  - app_en = 1, app_cmd = 001; a command fires on app_rdy, and app_addr steps per fire.
  - After command rd_length-1, go to READ_WAIT, unless all data has already returned, in which case go to DONE.
- Read data is counted in READ_CMD and READ_WAIT. rd_data and rd_data_valid are app_rd_data and app_rd_data_valid registered one cycle, and are forwarded only in READ_CMD and READ_WAIT. When the received count reaches rd_length, go to DONE.
- DONE: one cycle. Pulse wr_done or rd_done for the finished op, then return to IDLE.
- wr_busy = rd_busy = (state != IDLE) || !init_calib_complete.
- app_addr and both counters wrap silently (modulo 2^ADDR_W and 2^16 respectively); no boundary checks.
- Reset mid-burst: immediately return to IDLE and clear all counters. Read data returned late from an aborted burst is dropped.

## Timing
- Reset values: every output is 0, except busy, which is 1 while calibration is low. app_wdf_data and rd_data are 0.
- Request accepted at edge E; busy is high from the cycle after E. The requester may hold req one extra cycle; this is ignored outside IDLE.
- Throughput: 1 write beat per cycle when both ready signals are high. Read commands issue 1 per cycle while app_rdy is high.
- The done pulse comes 1 cycle after the last write fire, or in the same cycle as the final rd_data_valid.
- Busy stays high through the DONE cycle and drops the next cycle. This keeps a registered requester from re-requesting off a stale busy.
- Earliest next accept: 2 cycles after the last beat.

## Configuration
- MIG_BURST_RR_EN defined: round-robin arbitration. After each completed burst, priority goes to the other direction when both requests are pending.
- Undefined: fixed priority, write over read.

## Test plan
- Write, addr 0, len 256, both ready held high -> 256 consecutive wr_data_valid; app_addr runs 0..2040 in steps of 8; wr_done 1 cycle after the last fire; busy low 1 cycle after that.
- app_wdf_rdy toggled with period 3 during a len 16 write -> exactly 16 fires, none while app_wdf_rdy=0, and the data order is preserved (0..15).
- Read, addr 0x100, len 256, with app_rd_data_valid returning 20 cycles after each command -> 256 rd_data_valid in order; rd_done coincides with the 256th.
- wr_req and rd_req asserted together for 3 bursts -> undefined macro: W,W,W; MIG_BURST_RR_EN: W,R,W.
- init_calib_complete=0 with wr_req high -> busy=1 and no app_en; once calibration goes high, the write is accepted. A len 0 read gives rd_done 1 cycle after accept with no app_en.
- ui_rstn asserted at write beat 100 of 256 -> all outputs 0 immediately; after release, a new len 4 write starts at its own start address.
